button_mem_writer: RTL and testbench

- Writer-side counterpart to the VGA position fetcher, which reads fixed memory-mapped words every few cycles.
- Synchronizes and debounces the left, right and start buttons.
- Writes two fixed memory-mapped words through a request/grant write port: a level word and a sticky press-event word.
- Sits between the board pins and a spare memory write port arbitrated against the CPU; CPU game code polls the two words.

---
 rtl/button_mem_writer_pkg.sv | 19 +
 rtl/button_mem_writer_debouncer.sv | 57 +++++
 rtl/button_mem_writer.sv | 129 ++++++++++++
 tb/tb_button_mem_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_mem_writer_pkg.sv
// Shared definitions for the button memory writer: FSM states, button bit
// order and the memory-mapped addresses of the two button words.
package button_mem_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_STATE = 2'd1,
    ST_WR_PRESS = 2'd2
  } wr_state_e;

  localparam int unsigned NUM_BTN   = 3;
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_START = 2;

  localparam int unsigned BTN_ADDR_DEFAULT   = 6024;
  localparam int unsigned PRESS_ADDR_DEFAULT = 6028;

endpackage

// File: rtl/button_mem_writer_debouncer.sv
// One button: polarity fix, 2-flop synchronizer and a counter that only
// accepts a new level after it has held for DB_CYCLES cycles.
module button_mem_writer_debouncer #(
  parameter int unsigned DB_BITS    = 16,
  parameter int unsigned DB_CYCLES  = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic change
);

  localparam logic [DB_BITS-1:0] LAST_CNT = DB_BITS'(DB_CYCLES - 1);

  logic               pin_c;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               stable_q, stable_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  assign pin_c = ACTIVE_LOW ? ~pin : pin;

  always_comb begin
    sync1_d  = pin_c;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    change   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST_CNT) begin
        stable_d = sync2_q;
        change   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/button_mem_writer.sv
// Debounces left/right/start and publishes a level word and a sticky
// press-event word through a request/grant memory write port.
module button_mem_writer
  import button_mem_writer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DB_BITS    = 16,
  parameter int unsigned DB_CYCLES  = 50000,
  parameter int unsigned BTN_ADDR   = BTN_ADDR_DEFAULT,
  parameter int unsigned PRESS_ADDR = PRESS_ADDR_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             start,
  input  logic             wr_gnt,
  output logic             wr_req,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [2:0]       btn_state,
  output logic             busy
);

  logic [NUM_BTN-1:0] pins;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] change;
  logic [NUM_BTN-1:0] rise;

  wr_state_e          state_q, state_d;
  logic               dirty_q, dirty_d;
  logic [NUM_BTN-1:0] press_pend_q, press_pend_d;
  logic [NUM_BTN-1:0] press_snap_q, press_snap_d;
  logic               wr_req_q, wr_req_d;
  logic [WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;

  assign pins[BTN_LEFT]  = left;
  assign pins[BTN_RIGHT] = right;
  assign pins[BTN_START] = start;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_mem_writer_debouncer #(
      .DB_BITS    (DB_BITS),
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .pin    (pins[i]),
      .stable (stable[i]),
      .change (change[i])
    );
  end

  assign rise = change & ~stable;

  // Both words of a pass are fixed at WR_STATE entry; the press snapshot is
  // what gets cleared, so presses arriving mid-pass stay pending.
  always_comb begin
    state_d      = state_q;
    dirty_d      = dirty_q;
    press_pend_d = press_pend_q;
    press_snap_d = press_snap_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q) begin
          dirty_d      = 1'b0;
          state_d      = ST_WR_STATE;
          press_snap_d = press_pend_q;
          wr_req_d     = 1'b1;
          wr_addr_d    = WIDTH'(BTN_ADDR);
          wr_data_d    = {{(WIDTH-NUM_BTN){1'b0}}, stable};
        end
      end
      ST_WR_STATE: begin
        if (wr_gnt) begin
          state_d   = ST_WR_PRESS;
          wr_addr_d = WIDTH'(PRESS_ADDR);
          wr_data_d = {{(WIDTH-NUM_BTN){1'b0}}, press_snap_q};
        end
      end
      ST_WR_PRESS: begin
        if (wr_gnt) begin
          state_d      = ST_IDLE;
          wr_req_d     = 1'b0;
          press_pend_d = press_pend_q & ~press_snap_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
      end
    endcase
    press_pend_d = press_pend_d | rise;
    if (|change) dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dirty_q      <= 1'b0;
      press_pend_q <= '0;
      press_snap_q <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      press_pend_q <= press_pend_d;
      press_snap_q <= press_snap_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign btn_state = stable;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_mem_writer.sv
// Directed bench for button_mem_writer with DB_CYCLES=4 and active-low pins.
module tb_button_mem_writer;

  logic        clk;
  logic        reset;
  logic        left, right, start;
  logic        gnt_tie;
  logic        wr_gnt;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  btn_state;
  logic        busy;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;

  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int unsigned wc[$];

  button_mem_writer #(
    .WIDTH      (16),
    .DB_BITS    (16),
    .DB_CYCLES  (4),
    .BTN_ADDR   (6024),
    .PRESS_ADDR (6028),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .left      (left),
    .right     (right),
    .start     (start),
    .wr_gnt    (wr_gnt),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .btn_state (btn_state),
    .busy      (busy)
  );

  assign wr_gnt = gnt_tie & wr_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write log, sampled mid-cycle once stimulus for the cycle has settled.
  always @(negedge clk) begin
    #2;
    cyc = cyc + 1;
    if (wr_req && wr_gnt) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    left = 1'b1; right = 1'b1; start = 1'b1;
    gnt_tie = 1'b1;
    tick(2);
    reset = 1'b0;
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic test_reset();
    int unsigned req_seen;
    req_seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_req) req_seen++;
    end
    total++;
    if (btn_state !== 3'b000) begin bad++; $display("FAIL reset_btn: got %b want 000", btn_state); end
    total++;
    if (req_seen !== 0) begin bad++; $display("FAIL reset_req: got %0d req cycles want 0", req_seen); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_press_write();
    do_reset();
    @(negedge clk);
    left = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        total++;
        if (btn_state !== 3'b000) begin bad++; $display("FAIL press_early: got %b want 000", btn_state); end
      end
      if (k == 6) begin
        total++;
        if (btn_state !== 3'b001) begin bad++; $display("FAIL press_latency: got %b want 001", btn_state); end
      end
    end
    tick(6);
    total++;
    if (wa.size() !== 2) begin bad++; $display("FAIL press_count: got %0d writes want 2", wa.size()); end
    total++;
    if (wa[0] !== 16'd6024 || wd[0] !== 16'h0001)
      begin bad++; $display("FAIL press_w0: got %0d/%h want 6024/0001", wa[0], wd[0]); end
    total++;
    if (wa[1] !== 16'd6028 || wd[1] !== 16'h0001)
      begin bad++; $display("FAIL press_w1: got %0d/%h want 6028/0001", wa[1], wd[1]); end
    total++;
    if (wc[1] !== wc[0] + 1) begin bad++; $display("FAIL press_b2b: got cycles %0d,%0d want consecutive", wc[0], wc[1]); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL press_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int unsigned changed;
    changed = 0;
    do_reset();
    @(negedge clk);
    left = 1'b0;
    tick(3);
    left = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (btn_state != 3'b000) changed++;
    end
    total++;
    if (changed !== 0) begin bad++; $display("FAIL glitch_btn: got %0d changed cycles want 0", changed); end
    total++;
    if (wa.size() !== 0) begin bad++; $display("FAIL glitch_wr: got %0d writes want 0", wa.size()); end
  endtask

  task automatic test_stall();
    int unsigned hold_err;
    hold_err = 0;
    do_reset();
    gnt_tie = 1'b0;
    @(negedge clk);
    start = 1'b0;
    tick(8);
    for (int i = 0; i < 10; i++) begin
      if (wr_req !== 1'b1 || wr_addr !== 16'd6024 || wr_data !== 16'h0004) hold_err++;
      if (i == 2) right = 1'b0;
      @(negedge clk);
    end
    total++;
    if (hold_err !== 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", hold_err); end
    total++;
    if (btn_state !== 3'b110) begin bad++; $display("FAIL stall_btn: got %b want 110", btn_state); end
    total++;
    if (wa.size() !== 0) begin bad++; $display("FAIL stall_nowr: got %0d writes want 0", wa.size()); end
    gnt_tie = 1'b1;
    tick(12);
    total++;
    if (wa.size() !== 4) begin bad++; $display("FAIL stall_count: got %0d writes want 4", wa.size()); end
    total++;
    if (wa[0] !== 16'd6024 || wd[0] !== 16'h0004)
      begin bad++; $display("FAIL stall_w0: got %0d/%h want 6024/0004", wa[0], wd[0]); end
    total++;
    if (wa[1] !== 16'd6028 || wd[1] !== 16'h0004)
      begin bad++; $display("FAIL stall_w1: got %0d/%h want 6028/0004", wa[1], wd[1]); end
    total++;
    if (wa[2] !== 16'd6024 || wd[2] !== 16'h0006)
      begin bad++; $display("FAIL stall_w2: got %0d/%h want 6024/0006", wa[2], wd[2]); end
    total++;
    if (wa[3] !== 16'd6028 || wd[3] !== 16'h0002)
      begin bad++; $display("FAIL stall_w3: got %0d/%h want 6028/0002", wa[3], wd[3]); end
  endtask

  task automatic test_grant_collision();
    do_reset();
    @(negedge clk);
    left = 1'b0;
    tick(3);
    right = 1'b0;
    tick(15);
    total++;
    if (wa.size() !== 4) begin bad++; $display("FAIL coll_count: got %0d writes want 4", wa.size()); end
    total++;
    if (wa[1] !== 16'd6028 || wd[1] !== 16'h0001)
      begin bad++; $display("FAIL coll_w1: got %0d/%h want 6028/0001", wa[1], wd[1]); end
    total++;
    if (wa[2] !== 16'd6024 || wd[2] !== 16'h0003)
      begin bad++; $display("FAIL coll_w2: got %0d/%h want 6024/0003", wa[2], wd[2]); end
    total++;
    if (wa[3] !== 16'd6028 || wd[3] !== 16'h0002)
      begin bad++; $display("FAIL coll_w3: got %0d/%h want 6028/0002", wa[3], wd[3]); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    gnt_tie = 1'b0;
    @(negedge clk);
    left = 1'b0;
    tick(8);
    total++;
    if (wr_req !== 1'b1 || wr_addr !== 16'd6024)
      begin bad++; $display("FAIL mid_pre: got req=%b addr=%0d want 1/6024", wr_req, wr_addr); end
    reset = 1'b1;
    left = 1'b1;
    @(negedge clk);
    total++;
    if (wr_req !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_req: got req=%b busy=%b want 0/0", wr_req, busy); end
    total++;
    if (btn_state !== 3'b000 || wr_addr !== 16'd0 || wr_data !== 16'd0)
      begin bad++; $display("FAIL mid_out: got btn=%b addr=%0d data=%h want 000/0/0000", btn_state, wr_addr, wr_data); end
    reset = 1'b0;
    gnt_tie = 1'b1;
    tick(12);
    total++;
    if (wa.size() !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_after: got %0d writes busy=%b want 0/0", wa.size(), busy); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1;
    left = 1'b1; right = 1'b1; start = 1'b1;
    gnt_tie = 1'b1;
    test_reset();
    test_press_write();
    test_glitch();
    test_stall();
    test_grant_collision();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
